// File: rtl/lcd_lea_pkg.sv
//==============================================================================
// Module      : lcd_lea_pkg
// Description : Shared key codes, ASCII constants, states and byte-order helper
//               for the LCD / LEA plaintext path.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package lcd_lea_pkg;

  localparam int          NCHAR    = 16;
  localparam logic [7:0]  PAD_CHAR = 8'h20;
  localparam logic [NCHAR*8-1:0] PAD_LINE = {NCHAR{PAD_CHAR}};

  localparam logic [5:0] KEY_LETTER_LAST = 6'd25;
  localparam logic [5:0] KEY_DIGIT_FIRST = 6'd26;
  localparam logic [5:0] KEY_DIGIT_LAST  = 6'd35;
  localparam logic [5:0] KEY_SPACE       = 6'd36;
  localparam logic [5:0] KEY_BS          = 6'd60;
  localparam logic [5:0] KEY_CLR         = 6'd61;
  localparam logic [5:0] KEY_ENT         = 6'd62;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [0:0] {
    EDIT = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic       isChar;
    logic       isBs;
    logic       isClr;
    logic       isEnt;
    logic [7:0] ascii;
  } keyDecode_t;

  // Character 0 is the leftmost and occupies the top byte of the line.
  function automatic int charLsb(input logic [3:0] idx);
    return (NCHAR - 1 - int'(idx)) * 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plaintext_entry_buffer_if.sv
//==============================================================================
// Module      : plaintext_entry_buffer_if
// Description : Keypad input, LCD text output and cipher handshake bundle.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface plaintext_entry_buffer_if;
  import lcd_lea_pkg::*;

  logic                 KEY_VALID;
  logic [5:0]           KEY_CODE;
  logic                 PT_READY;
  logic [NCHAR*8-1:0]   TEXT_ASCII;
  logic [4:0]           CURSOR;
  logic                 FULL;
  logic                 PT_VALID;
  logic [NCHAR*8-1:0]   PT_DATA;
  logic                 BUSY;

  modport master (
    output KEY_VALID, KEY_CODE, PT_READY,
    input  TEXT_ASCII, CURSOR, FULL, PT_VALID, PT_DATA, BUSY
  );

  modport slave (
    input  KEY_VALID, KEY_CODE, PT_READY,
    output TEXT_ASCII, CURSOR, FULL, PT_VALID, PT_DATA, BUSY
  );

endinterface

`default_nettype wire

// File: rtl/plaintext_entry_buffer_key_code_to_ascii.sv
//==============================================================================
// Module      : key_code_to_ascii
// Description : Combinational map from 6-bit keypad code to character/command.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module key_code_to_ascii
  import lcd_lea_pkg::*;
(
  input  logic [5:0]  i_code,
  output keyDecode_t  o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_code <= KEY_LETTER_LAST) begin
      o_dec.isChar = 1'b1;
      o_dec.ascii  = ASCII_A + {2'b00, i_code};
    end else if (i_code <= KEY_DIGIT_LAST) begin
      o_dec.isChar = 1'b1;
      o_dec.ascii  = ASCII_0 + {2'b00, 6'(i_code - KEY_DIGIT_FIRST)};
    end else begin
      case (i_code)
        KEY_SPACE: begin
          o_dec.isChar = 1'b1;
          o_dec.ascii  = ASCII_SPACE;
        end
        KEY_BS:  o_dec.isBs  = 1'b1;
        KEY_CLR: o_dec.isClr = 1'b1;
        KEY_ENT: o_dec.isEnt = 1'b1;
        default: o_dec = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/plaintext_entry_buffer.sv
//==============================================================================
// Module      : plaintext_entry_buffer
// Description : Assembles a 16-character keypad line and hands it to LEA on ENTER.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module plaintext_entry_buffer
  import lcd_lea_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RESETN,
  plaintext_entry_buffer_if.slave   bus
);

  logic [NCHAR*8-1:0] r_text;
  logic [4:0]         r_cursor;
  logic               r_ptValid;
  logic [NCHAR*8-1:0] r_ptData;
  logic               r_keyPrev;
  state_t             r_state;

  keyDecode_t         w_dec;
  logic               w_keyEdge;
  logic [3:0]         w_prevIdx;
  logic               w_full;

  key_code_to_ascii u_decode (
    .i_code (bus.KEY_CODE),
    .o_dec  (w_dec)
  );

  assign w_keyEdge = bus.KEY_VALID & ~r_keyPrev;
  assign w_prevIdx = 4'(r_cursor - 5'd1);
  assign w_full    = (r_cursor == 5'(NCHAR));

  // Reset polarity is high despite the RESETN name; kept for codebase compatibility.
  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      r_text    <= PAD_LINE;
      r_cursor  <= '0;
      r_ptValid <= 1'b0;
      r_ptData  <= '0;
      r_keyPrev <= 1'b0;
      r_state   <= EDIT;
    end else begin
      r_keyPrev <= bus.KEY_VALID;
      case (r_state)
        EDIT: begin
          if (w_keyEdge) begin
            if (w_dec.isChar) begin
              if (!w_full) begin
                r_text[charLsb(r_cursor[3:0]) +: 8] <= w_dec.ascii;
                r_cursor <= r_cursor + 5'd1;
              end
            end else if (w_dec.isBs) begin
              if (r_cursor != '0) begin
                r_text[charLsb(w_prevIdx) +: 8] <= PAD_CHAR;
                r_cursor <= r_cursor - 5'd1;
              end
            end else if (w_dec.isClr) begin
              r_text   <= PAD_LINE;
              r_cursor <= '0;
            end else if (w_dec.isEnt) begin
              if (r_cursor != '0) begin
                r_ptData  <= r_text;
                r_ptValid <= 1'b1;
                r_state   <= SEND;
              end
            end
          end
        end
        SEND: begin
          // Keys pressed here, including one coinciding with PT_READY, are dropped.
          if (bus.PT_READY) begin
            r_ptValid <= 1'b0;
            r_text    <= PAD_LINE;
            r_cursor  <= '0;
            r_state   <= EDIT;
          end
        end
        default: r_state <= EDIT;
      endcase
    end
  end

  assign bus.TEXT_ASCII = r_text;
  assign bus.CURSOR     = r_cursor;
  assign bus.FULL       = w_full;
  assign bus.PT_VALID   = r_ptValid;
  assign bus.PT_DATA    = r_ptData;
  assign bus.BUSY       = (r_state == SEND);

endmodule

`default_nettype wire

// File: tb/tb_plaintext_entry_buffer.sv
//==============================================================================
// Module      : tb_plaintext_entry_buffer
// Description : Directed vector bench for the plaintext entry buffer.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_plaintext_entry_buffer;

  logic CLK;
  logic RESETN;

  plaintext_entry_buffer_if bus ();

  plaintext_entry_buffer dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]   code;
    int           hold;
    logic [4:0]   expCursor;
    logic         expFull;
    logic         expPtValid;
    logic         chkText;
    logic [127:0] expText;
  } vec_t;

  localparam logic [127:0] PAD16  = {16{8'h20}};
  localparam logic [127:0] HELLO  = {40'h48454C4C4F, {11{8'h20}}};
  localparam logic [127:0] HELLOA = {48'h48454C4C4F41, {10{8'h20}}};
  localparam logic [127:0] DIGITS = 128'h30313233343536373839414243444546;
  localparam logic [127:0] LEA    = {24'h4C4541, {13{8'h20}}};

  vec_t tbl[$];
  int   nPass  = 0;
  int   nTotal = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input int code, input int hold, input int cur,
                              input bit full, input bit ptv, input bit ct,
                              input logic [127:0] txt);
    vec_t v;
    v.code = 6'(code); v.hold = hold; v.expCursor = 5'(cur);
    v.expFull = full; v.expPtValid = ptv; v.chkText = ct; v.expText = txt;
    return v;
  endfunction

  task automatic press(input logic [5:0] code, input int hold);
    @(negedge CLK);
    bus.KEY_CODE  = code;
    bus.KEY_VALID = 1'b1;
    repeat (hold) @(negedge CLK);
    bus.KEY_VALID = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [127:0] heldData;

    // HELLO, then a long hold of 'A', then clear
    tbl.push_back(mk(7, 1, 1, 0, 0, 0, '0));
    tbl.push_back(mk(4, 1, 2, 0, 0, 0, '0));
    tbl.push_back(mk(11, 1, 3, 0, 0, 0, '0));
    tbl.push_back(mk(11, 1, 4, 0, 0, 0, '0));
    tbl.push_back(mk(14, 1, 5, 0, 0, 1, HELLO));
    tbl.push_back(mk(0, 50, 6, 0, 0, 1, HELLOA));
    tbl.push_back(mk(61, 1, 0, 0, 0, 1, PAD16));
    // '0'..'9','A'..'F' fill the line; 'G' must be dropped
    for (int i = 0; i < 10; i++) tbl.push_back(mk(26 + i, 1, i + 1, 0, 0, 0, '0));
    for (int i = 0; i < 5; i++)  tbl.push_back(mk(i, 1, 11 + i, 0, 0, 0, '0));
    tbl.push_back(mk(5, 1, 16, 1, 0, 1, DIGITS));
    tbl.push_back(mk(6, 1, 16, 1, 0, 1, DIGITS));
    tbl.push_back(mk(61, 1, 0, 0, 0, 1, PAD16));
    // backspace past zero, unmapped codes, ENTER on empty line
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, '0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, '0));
    tbl.push_back(mk(60, 1, 1, 0, 0, 0, '0));
    tbl.push_back(mk(60, 1, 0, 0, 0, 0, '0));
    tbl.push_back(mk(60, 1, 0, 0, 0, 1, PAD16));
    tbl.push_back(mk(40, 1, 0, 0, 0, 0, '0));
    tbl.push_back(mk(63, 1, 0, 0, 0, 1, PAD16));
    tbl.push_back(mk(62, 1, 0, 0, 0, 1, PAD16));

    bus.KEY_VALID = 1'b0;
    bus.KEY_CODE  = '0;
    bus.PT_READY  = 1'b0;
    RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);

    chk("reset_text",   bus.TEXT_ASCII, PAD16);
    chk("reset_cursor", 128'(bus.CURSOR), 128'd0);
    chk("reset_full",   128'(bus.FULL), 128'd0);
    chk("reset_ptv",    128'(bus.PT_VALID), 128'd0);
    chk("reset_ptdata", bus.PT_DATA, 128'd0);
    chk("reset_busy",   128'(bus.BUSY), 128'd0);

    foreach (tbl[i]) begin
      press(tbl[i].code, tbl[i].hold);
      chk($sformatf("v%0d_cursor", i), 128'(bus.CURSOR), 128'(tbl[i].expCursor));
      chk($sformatf("v%0d_full", i),   128'(bus.FULL), 128'(tbl[i].expFull));
      chk($sformatf("v%0d_ptv", i),    128'(bus.PT_VALID), 128'(tbl[i].expPtValid));
      if (tbl[i].chkText)
        chk($sformatf("v%0d_text", i), bus.TEXT_ASCII, tbl[i].expText);
    end

    // LEA, ENTER, cipher stalls while 'Z' and CLEAR are pressed
    press(6'd11, 1);
    press(6'd4, 1);
    press(6'd0, 1);
    press(6'd62, 1);
    chk("send_ptv",    128'(bus.PT_VALID), 128'd1);
    chk("send_busy",   128'(bus.BUSY), 128'd1);
    chk("send_ptdata", bus.PT_DATA, LEA);
    heldData = bus.PT_DATA;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("stall%0d_ptv", i),  128'(bus.PT_VALID), 128'd1);
      chk($sformatf("stall%0d_data", i), bus.PT_DATA, heldData);
      bus.KEY_VALID = (i == 2 || i == 3 || i == 6);
      bus.KEY_CODE  = (i == 6) ? 6'd61 : 6'd25;
    end
    bus.KEY_VALID = 1'b0;
    @(negedge CLK);
    chk("stall_cursor", 128'(bus.CURSOR), 128'd3);
    chk("stall_text",   bus.TEXT_ASCII, LEA);

    // key rises together with PT_READY and is held into EDIT: must not replay
    bus.KEY_CODE  = 6'd25;
    bus.KEY_VALID = 1'b1;
    bus.PT_READY  = 1'b1;
    @(negedge CLK);
    bus.PT_READY  = 1'b0;
    chk("done_ptv",    128'(bus.PT_VALID), 128'd0);
    chk("done_busy",   128'(bus.BUSY), 128'd0);
    chk("done_cursor", 128'(bus.CURSOR), 128'd0);
    chk("done_text",   bus.TEXT_ASCII, PAD16);
    repeat (3) @(negedge CLK);
    chk("held_noreplay", 128'(bus.CURSOR), 128'd0);
    bus.KEY_VALID = 1'b0;
    @(negedge CLK);

    // asynchronous reset in the middle of SEND
    press(6'd0, 1);
    press(6'd62, 1);
    chk("pre_rst_busy", 128'(bus.BUSY), 128'd1);
    #1 RESETN = 1'b1;
    #1;
    chk("arst_ptv",    128'(bus.PT_VALID), 128'd0);
    chk("arst_busy",   128'(bus.BUSY), 128'd0);
    chk("arst_cursor", 128'(bus.CURSOR), 128'd0);
    chk("arst_text",   bus.TEXT_ASCII, PAD16);
    @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule

`default_nettype wire
